// File: rtl/vid_stream_pkg.sv
// vid_stream_pkg: shared definitions for the video stream arbiter and the
// test-pattern generators feeding it.
//   - arb_state_e : arbiter state encoding (IDLE / SYNC / PASS)
//   - VID_DATA_W  : default pixel width (8/8/8 RGB), used as DATA_W default
//   - 720p raster constants (active and total timing, pixel clock)
//   - cnt_w()     : counter width helper that never returns 0
package vid_stream_pkg;

  localparam int VID_DATA_W      = 24;

  localparam int H_ACTIVE_720P   = 1280;
  localparam int V_ACTIVE_720P   = 720;
  localparam int H_TOTAL_720P    = 1650;
  localparam int V_TOTAL_720P    = 750;
  localparam int PIX_CLK_HZ_720P = 74_250_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_PASS = 2'd2
  } arb_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vid_raster_tracker.sv
// vid_raster_tracker: x/y position of the forwarded stream.
// Ports:
//   clk, resetn  : clock, async active-low reset
//   clear        : synchronous restart at (0,0) (frame start found)
//   hs           : accepted beat on the output stream
//   tuser, tlast : sideband of the accepted beat
//   frame_end    : accepted tlast on the last line (combinational)
//   err_evt      : accepted beat violates raster framing (combinational)
module vid_raster_tracker
  import vid_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic hs,
  input  logic tuser,
  input  logic tlast,
  output logic frame_end,
  output logic err_evt
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_last, y_last;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  // tlast always closes the line, even when early, so the next line starts
  // cleanly at x=0. A missing tlast parks x at its last value rather than
  // running past the line length.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (hs) begin
      if (tlast) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else if (!x_last) begin
        x <= x + 1'b1;
      end
    end
  end

  assign frame_end = hs & tlast & y_last;
  assign err_evt   = hs & ((tlast & ~x_last) |
                           (~tlast & x_last) |
                           (tuser & ((x != '0) | (y != '0))));

endmodule

// File: rtl/vid_src_arbiter.sv
// vid_src_arbiter: shares one AXI4-Stream video output between two sources,
// switching only on frame boundaries.
// Ports:
//   clk, resetn           : clock, async active-low reset
//   i_enable, i_sel       : run request / requested source, sampled in IDLE
//                           and at frame end only
//   s0_* / s1_*           : source streams (tdata, tvalid, tuser, tlast, tready)
//   m_*                   : output stream, zero-latency pass-through in PASS
//   o_active_src          : source currently selected
//   o_busy                : not IDLE
//   o_frame_done          : one-cycle pulse after a frame's last beat
//   o_err                 : sticky framing error, cleared in IDLE
// Build option: DRAIN_UNSEL_EN - unselected source is drained (tready=1)
// whenever not IDLE instead of being back-pressured.
module vid_src_arbiter
  import vid_stream_pkg::*;
#(
  parameter int DATA_W   = VID_DATA_W,
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_enable,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tuser,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tuser,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tuser,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              o_active_src,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err
);

  arb_state_e  state, state_nxt;
  logic        cur_src, src_nxt;

  logic [DATA_W-1:0] sel_tdata;
  logic        sel_tvalid, sel_tuser, sel_tlast;
  logic        sel_rdy, unsel_rdy;
  logic        sync_hit, hs, frame_end, err_evt;

  assign sel_tdata  = cur_src ? s1_tdata  : s0_tdata;
  assign sel_tvalid = cur_src ? s1_tvalid : s0_tvalid;
  assign sel_tuser  = cur_src ? s1_tuser  : s0_tuser;
  assign sel_tlast  = cur_src ? s1_tlast  : s0_tlast;

  // Frame start on the selected source; in SYNC it is left unconsumed so it
  // becomes the first beat forwarded in PASS.
  assign sync_hit = sel_tvalid & sel_tuser;
  assign hs       = m_tvalid & m_tready;

  // ---- state register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cur_src <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_src <= src_nxt;
    end
  end

  // ---- next state ----
  always_comb begin
    state_nxt = state;
    src_nxt   = cur_src;
    unique case (state)
      ST_IDLE: if (i_enable) begin
        src_nxt   = i_sel;
        state_nxt = ST_SYNC;
      end
      ST_SYNC: if (sync_hit) state_nxt = ST_PASS;
      ST_PASS: if (frame_end) begin
        if (!i_enable) begin
          state_nxt = ST_IDLE;
        end else if (i_sel != cur_src) begin
          src_nxt   = i_sel;
          state_nxt = ST_SYNC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tuser   = 1'b0;
    m_tlast   = 1'b0;
    sel_rdy   = 1'b0;
    unique case (state)
      ST_SYNC: sel_rdy = ~sync_hit;
      ST_PASS: begin
        m_tvalid = sel_tvalid;
        m_tdata  = sel_tdata;
        m_tuser  = sel_tuser;
        m_tlast  = sel_tlast;
        sel_rdy  = m_tready;
      end
      default: ;
    endcase
`ifdef DRAIN_UNSEL_EN
    unsel_rdy = (state != ST_IDLE);
`else
    unsel_rdy = 1'b0;
`endif
    s0_tready = cur_src ? unsel_rdy : sel_rdy;
    s1_tready = cur_src ? sel_rdy   : unsel_rdy;
  end

  assign o_active_src = cur_src;
  assign o_busy       = (state != ST_IDLE);

  vid_raster_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .clear     ((state == ST_SYNC) & sync_hit),
    .hs        (hs),
    .tuser     (sel_tuser),
    .tlast     (sel_tlast),
    .frame_end (frame_end),
    .err_evt   (err_evt)
  );

  // hs is only possible in PASS, so frame_end/err_evt need no state gating.
  // Leaving for IDLE wins over a same-cycle error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      if (state_nxt == ST_IDLE) o_err <= 1'b0;
      else if (err_evt)         o_err <= 1'b1;
    end
  end

endmodule

// File: doc/vid_src_arbiter.md
Name: vid_src_arbiter

Overview:
- Shares one AXI4-Stream video output (24-bit RGB, 720p raster) between two pattern-generator sources.
- Source switching happens only on frame boundaries, so the downstream VDMA/video-out never sees a torn frame.
- Tracks the x/y position of the forwarded stream, flags malformed lines and frames, and pulses once per completed frame.
- Sits between the test-pattern generators and the stream-to-video output stage.

Parameters:
DATA_W, 24, pixel width (8/8/8 RGB)
H_ACTIVE, 1280, beats per line; tlast expected on beat H_ACTIVE-1
V_ACTIVE, 720, lines per frame

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock, asynchronous, active-low
i_enable  in  1  run request; sampled at IDLE and at frame end
i_sel  in  1  requested source (0 = s0, 1 = s1); sampled only at frame boundaries
s0_tdata / s1_tdata  in  DATA_W  source pixel
s0_tvalid / s1_tvalid  in  1  source valid
s0_tuser / s1_tuser  in  1  start of frame (first beat of a frame)
s0_tlast / s1_tlast  in  1  end of line
s0_tready / s1_tready  out  1  source ready
m_tdata  out  DATA_W  output pixel
m_tvalid  out  1  output valid
m_tuser  out  1  output start of frame
m_tlast  out  1  output end of line
m_tready  in  1  downstream ready
o_active_src  out  1  source currently forwarded
o_busy  out  1  state is not IDLE
o_frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted
o_err  out  1  sticky framing error

Behaviour:
- Reset values: all registered outputs are 0; state is IDLE; x/y counters are 0.
- m_tvalid, m_tuser, m_tlast, m_tdata and both treadys are combinational from state and cur_src, so they are 0 while in reset.
- States:
  - IDLE:
    - m_tvalid=0, both treadys=0.
    - If i_enable=1: cur_src<=i_sel, go to SYNC.
  - SYNC:
    - Selected source tready=1; beats with tuser=0 are discarded.
    - On a tvalid&tuser beat: that beat gets tready=0 (not consumed), x=y=0, go to PASS.
    - m_tvalid=0 throughout SYNC.
  - PASS:
    - Zero-latency pass-through: m_* = selected s*_*, selected tready = m_tready.
    - Handshake is m_tvalid & m_tready.
    - On each handshake: x++. On a tlast handshake: x<=0, y++.
    - Frame end is a tlast handshake with y==V_ACTIVE-1:
      - y<=0; o_frame_done=1 on the next cycle.
      - Then sample i_enable and i_sel:
        - i_enable=0 → IDLE.
        - i_sel==cur_src → stay in PASS.
        - otherwise cur_src<=i_sel → SYNC.
- Unselected source tready follows the DRAIN_UNSEL_EN rule below.
- Mid-frame changes of i_sel or i_enable are ignored; the current frame always completes.
- o_err is set (sticky) when any of these occurs in PASS:
  - a tlast handshake with x!=H_ACTIVE-1;
  - a handshake at x==H_ACTIVE-1 without tlast;
  - a tuser handshake with (x,y)!=(0,0).
  The data is still forwarded. o_err is cleared by reset or by entering IDLE.
- x width is clog2(H_ACTIVE); y width is clog2(V_ACTIVE). Counters never exceed their terminal values: the bad-tlast case still resets x.
- Reset asserted mid-frame: immediate return to the reset state, with no drain and no o_frame_done.
- o_active_src = cur_src; o_busy = (state!=IDLE).

Optional Feature:
- Macro DRAIN_UNSEL_EN.
- Defined: the unselected source tready=1 whenever state!=IDLE. Its beats are discarded, so that generator free-runs and stays frame-aligned in time.
- Undefined: the unselected source tready=0 (backpressure). The generator stalls mid-frame; SYNC realigns it to the next tuser when it becomes selected.

Decomposition:
- Package vid_stream_pkg: state encoding (IDLE/SYNC/PASS), DATA_W, default H_ACTIVE/V_ACTIVE, the 720p constants shared with the pattern generators.
- Sub-module vid_raster_tracker: x/y counters, frame-end detect and error checks. Inputs are handshake, tuser, tlast and clear; outputs are frame_end and err_evt.

Test Plan:
1. Enable=1, sel=0, s0 a clean 1280x720 frame, m_tready=1 → 921600 beats on m_*, exactly one o_frame_done, o_err=0, s1_tready=0 (macro off).
2. sel toggled to 1 at line 300 of s0's frame → s0's frame completes; the next output frame comes from s1 starting at its tuser; o_active_src goes 1 the cycle after frame end.
3. s1 is mid-frame (x=500, y=10) when selected → SYNC discards s1 beats until its tuser; the first m_tvalid beat has m_tuser=1.
4. s0 asserts tlast at x=1000 → o_err=1 and stays 1; the following beats forward with x restarting at 0.
5. Random m_tready stalls (50%) → m_tdata/m_tuser/m_tlast match s0 beat-for-beat, with no drops or duplicates.
6. resetn pulsed low at x=640, y=360 → all outputs 0 asynchronously; after release the block stays in IDLE until i_enable=1 and resyncs on tuser.
